// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: function codes, FSM states,
// operand widths and the per-operation control flags latched at issue.
package mdu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DLEN  = 2 * XLEN;
  localparam int unsigned CNT_W = 5;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  // MDU function codes, alongside the ALU function codes
  typedef enum logic [2:0] {
    mduNone  = 3'd0,
    mduMult  = 3'd1,
    mduMultu = 3'd2,
    mduDiv   = 3'd3,
    mduDivu  = 3'd4,
    mduMthi  = 3'd5,
    mduMtlo  = 3'd6
  } mdu_func_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // Flags captured at issue that steer iteration and the final sign fixup
  typedef struct packed {
    logic is_div;
    logic neg_q;
    logic neg_r;
    logic div0;
  } mdu_op_t;

endpackage

// File: rtl/mdu.sv
// Iterative 32-cycle multiply/divide unit holding the architectural HI/LO
// registers; MTHI/MTLO complete in a single cycle.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  ctrl_mdu_func,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] ma_q, ma_d;
  logic [XLEN-1:0] mb_q, mb_d;
  mdu_op_t         op_q, op_d;
  logic [XLEN-1:0] hi_d, lo_d;
  logic            busy_d, done_d;

  mdu_func_e       func;
  logic            is_iter_c;
  logic            is_signed_c;
  logic            a_neg_c, b_neg_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c;

  assign func        = mdu_func_e'(ctrl_mdu_func);
  assign is_iter_c   = start && (func inside {mduMult, mduMultu, mduDiv, mduDivu});
  assign is_signed_c = (func == mduMult) || (func == mduDiv);
  assign a_neg_c     = is_signed_c && A[XLEN-1];
  assign b_neg_c     = is_signed_c && B[XLEN-1];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign a_mag_c     = a_neg_c ? (~A + 32'd1) : A;
  assign b_mag_c     = b_neg_c ? (~B + 32'd1) : B;

  // One shift-add multiply step: product bits enter from the top of acc
  logic [XLEN:0]   add_sum;
  assign add_sum = {1'b0, acc_q[DLEN-1:XLEN]} + (mb_q[0] ? {1'b0, ma_q} : 33'd0);

  // One restoring divide step on a 33-bit partial remainder
  logic [XLEN:0]   shifted;
  logic            q_bit;
  logic [XLEN-1:0] rem_next;
  assign shifted  = {acc_q[DLEN-1:XLEN], ma_q[XLEN-1]};
  assign q_bit    = (shifted >= {1'b0, mb_q});
  assign rem_next = q_bit ? 32'(shifted - {1'b0, mb_q}) : shifted[XLEN-1:0];

  logic [DLEN-1:0] acc_step;
  assign acc_step = op_q.is_div ? {rem_next, acc_q[XLEN-2:0], q_bit}
                                : {add_sum, acc_q[XLEN-1:1]};

  // Sign fixup applied to the final iteration's result
  logic [DLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;
  assign prod_fix = op_q.neg_q ? (~acc_step + 64'd1) : acc_step;
  assign quo_fix  = op_q.div0 ? 32'hFFFF_FFFF
                  : (op_q.neg_q ? (~acc_step[XLEN-1:0] + 32'd1) : acc_step[XLEN-1:0]);
  assign rem_fix  = op_q.neg_r ? (~acc_step[DLEN-1:XLEN] + 32'd1) : acc_step[DLEN-1:XLEN];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_iter_c) state_d = RUN;
      RUN:     if (cnt_q == LAST_ITER) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    ma_d   = ma_q;
    mb_d   = mb_q;
    op_d   = op_q;
    hi_d   = hi;
    lo_d   = lo;
    done_d = 1'b0;
    busy_d = (state_d == RUN);
    case (state_q)
      IDLE: begin
        if (start) begin
          case (func)
            mduMult, mduMultu, mduDiv, mduDivu: begin
              cnt_d       = '0;
              acc_d       = '0;
              ma_d        = a_mag_c;
              mb_d        = b_mag_c;
              op_d.is_div = (func == mduDiv) || (func == mduDivu);
              op_d.neg_q  = a_neg_c ^ b_neg_c;
              op_d.neg_r  = a_neg_c;
              op_d.div0   = (B == 32'd0);
            end
            mduMthi: hi_d = A;
            mduMtlo: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q + 5'd1;
        acc_d = acc_step;
        if (op_q.is_div) ma_d = {ma_q[XLEN-2:0], 1'b0};
        else             mb_d = {1'b0, mb_q[XLEN-1:1]};
        if (cnt_q == LAST_ITER) begin
          done_d = 1'b1;
          if (op_q.is_div) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[DLEN-1:XLEN];
            lo_d = prod_fix[XLEN-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      ma_q  <= '0;
      mb_q  <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      ma_q  <= ma_d;
      mb_q  <= mb_d;
      op_q  <= op_d;
      hi    <= hi_d;
      lo    <= lo_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Randomized scoreboard bench for mdu: expected HI/LO pushed at issue,
// compared by an independent monitor whenever done pulses.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  func_drv;
  logic [31:0] a_drv, b_drv;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb_q[$];
  logic [31:0] mh = '0, ml = '0;
  logic        prev_done = 1'b0;

  mdu dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctrl_mdu_func(func_drv),
    .A(a_drv), .B(b_drv), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV integer division truncates toward zero
  function automatic logic [63:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (f)
      3'd1: r = 64'(sa * sb);
      3'd2: r = {32'd0, a} * {32'd0, b};
      3'd3: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      3'd4: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (prev_done) begin
        checks++; failures++;
        $display("FAIL done_width: got done high two cycles, required one");
      end
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: got done with empty scoreboard, required none");
      end else begin
        check("result_hi_lo", {hi, lo}, sb_q.pop_front());
      end
    end
    prev_done <= done;
  end

  task automatic run_iter(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    logic stale_bad;
    logic [63:0] e;
    e = ref_result(f, a, b);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; func_drv = f; a_drv = a; b_drv = b;
    @(negedge clk);
    start = 1'b0; func_drv = 3'($urandom_range(0, 7)); a_drv = $urandom; b_drv = $urandom;
    cyc = 0;
    stale_bad = 1'b0;
    while (busy && cyc < 40) begin
      if (hi !== mh || lo !== ml) stale_bad = 1'b1;
      cyc++;
      @(negedge clk);
    end
    func_drv = mduNone;
    check("busy_cycles", 64'(cyc), 64'd32);
    check("hilo_stale_during_run", {63'd0, stale_bad}, 64'd0);
    {mh, ml} = e;
  endtask

  task automatic run_mt(input logic [2:0] f, input logic [31:0] a);
    if (f == mduMthi) mh = a;
    if (f == mduMtlo) ml = a;
    @(negedge clk);
    start = 1'b1; func_drv = f; a_drv = a; b_drv = $urandom;
    @(negedge clk);
    start = 1'b0; func_drv = mduNone;
    check("mt_hi_lo", {hi, lo}, {mh, ml});
    check("mt_busy_low", {63'd0, busy}, 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials[4];
    specials[0] = 32'h0;
    specials[1] = 32'h8000_0000;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h1;
    if ($urandom_range(0, 5) == 0) return specials[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; func_drv = mduNone; a_drv = '0; b_drv = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
    rst_n = 1'b1;

    // Directed cases
    run_iter(mduMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_iter(mduMult,  32'hFFFF_FFFE, 32'd3);
    run_iter(mduDiv,   32'hFFFF_FFF9, 32'd2);
    run_iter(mduDivu,  32'd100,       32'd0);
    run_iter(mduDiv,   32'h8000_0000, 32'hFFFF_FFFF);
    run_iter(mduDiv,   32'hFFFF_FFF9, 32'd0);
    run_iter(mduMult,  32'h8000_0000, 32'h8000_0000);
    run_mt(mduMthi, 32'hCAFE_F00D);
    run_mt(mduMtlo, 32'h0BAD_BEEF);
    run_mt(mduNone, 32'h1111_1111);
    run_mt(3'd7,    32'h2222_2222);

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      f = 3'($urandom_range(1, 4));
      run_iter(f, pick_operand(), pick_operand());
    end

    // MTHI while busy is ignored; reset mid-multiply discards the operation
    run_mt(mduMthi, 32'h0000_DEAD);
    @(negedge clk);
    start = 1'b1; func_drv = mduMult; a_drv = $urandom; b_drv = $urandom;
    @(negedge clk);
    start = 1'b0; func_drv = mduNone;
    repeat (4) @(negedge clk);
    start = 1'b1; func_drv = mduMthi; a_drv = 32'h1234;
    @(negedge clk);
    start = 1'b0; func_drv = mduNone;
    check("mthi_while_busy_hi", {32'd0, hi}, {32'd0, mh});
    check("mthi_while_busy_busy", {63'd0, busy}, 64'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
    mh = '0; ml = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_mt(mduMtlo, 32'h55);
    repeat (40) @(negedge clk);
    check("no_late_done_scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
